// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Load/store bus between the MEM stage (master) and the data-memory
// responder (slave).
//   req_valid   MEM stage has a request           (master -> slave)
//   req_write   1 = store, 0 = load               (master -> slave)
//   req_funct3  RV32I width/sign code             (master -> slave)
//   req_addr    byte address                      (master -> slave)
//   req_wdata   store data, low bytes for SB/SH   (master -> slave)
//   req_ready   responder can accept              (slave -> master)
//   resp_valid  one-cycle completion pulse        (slave -> master)
//   ReadData    extended load result              (slave -> master)
//   resp_err    misaligned / illegal access       (slave -> master)
//   stall       freeze PC/IF/ID/EX/MEM            (slave -> master)
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  resp_err;
    logic                  stall;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, ReadData, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, ReadData, resp_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// MEM-stage data memory with configurable wait states. Accepts one RV32I
// load/store in IDLE, waits LATENCY edges in BUSY, performs the access and
// pulses resp_valid for one RESP cycle. Stall freezes the pipeline meanwhile.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of data_mem_responder_if (request/response/stall)
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus
);
    localparam int WAW   = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** WAW;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic                    write_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    commit;
    logic [WAW-1:0]          word_idx;
    logic [31:0]             rd_word;
    logic [31:0]             rd_shift;
    logic [31:0]             wr_word;
    logic [3:0]              be;

    assign accept   = (state_q == IDLE) && bus.req_valid;
    assign commit   = (state_q == BUSY) && (cnt_q == '0);
    assign word_idx = addr_q[ADDR_WIDTH-1:2];

    // State register plus captured request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= CW'(LATENCY - 1);
                write_q <= bus.req_write;
                f3_q    <= bus.req_funct3;
                // Upper address bits are dropped here, which gives the wrap.
                addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
                wdata_q <= bus.req_wdata;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = BUSY;
            BUSY:    if (cnt_q == '0)   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. RESP keeps req_ready low so the still-held request is not
    // taken twice; the pipeline advances on the RESP edge.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.stall      = (state_q == BUSY) || ((state_q == IDLE) && bus.req_valid);
        bus.ReadData   = rdata_q;
        bus.resp_err   = err_q;
    end

    // Error decode: misaligned halfword/word, or funct3 illegal for the op.
    always_comb begin
        err_d = 1'b0;
        case (f3_q)
            3'b000:  err_d = 1'b0;
            3'b001:  err_d = addr_q[0];
            3'b010:  err_d = (addr_q[1:0] != 2'b00);
            3'b100,
            3'b101:  err_d = write_q;
            default: err_d = 1'b1;
        endcase
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be      = 4'b0000;
        wr_word = wdata_q;
        case (f3_q)
            3'b000: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be      = 4'b0011 << addr_q[1:0];
                wr_word = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                be      = 4'b1111;
                wr_word = wdata_q;
            end
            default: begin
                be      = 4'b0000;
                wr_word = wdata_q;
            end
        endcase
    end

    // Memory as four byte lanes of words: aligned accesses never straddle a
    // word, so one index serves every lane. Reset does not clear contents and
    // an aborted store never reaches commit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            always_ff @(posedge clk) begin
                if (commit && write_q && !err_d && be[gi]) begin
                    mem[word_idx] <= wr_word[8*gi +: 8];
                end
            end
            assign rd_word[8*gi +: 8] = mem[word_idx];
        end
    endgenerate

    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

    // Load extension; stores and errors return zero.
    always_comb begin
        rdata_d = '0;
        if (!err_d && !write_q) begin
            case (f3_q)
                3'b000:  rdata_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
                3'b001:  rdata_d = {{16{rd_shift[15]}}, rd_shift[15:0]};
                3'b010:  rdata_d = rd_word;
                3'b100:  rdata_d = {24'h0, rd_shift[7:0]};
                3'b101:  rdata_d = {16'h0, rd_shift[15:0]};
                default: rdata_d = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed load/store vectors; expected responses are queued when a request
// is issued and popped by a monitor whenever resp_valid is seen.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic clk;
    logic rst_n;

    data_mem_responder_if #(.DATA_WIDTH(32)) bus ();

    data_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .LATENCY   (LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_resp: got resp with data %h, required none", bus.ReadData);
                end else begin
                    e = sb_q.pop_front();
                    $display("resp %-10s data=%h err=%b (exp %h/%b)", e.name, bus.ReadData, bus.resp_err, e.data, e.err);
                    check({e.name, "_data"}, bus.ReadData, e.data);
                    check({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
                    check({e.name, "_ready_in_resp"}, 32'(bus.req_ready), 32'd0);
                    check({e.name, "_stall_in_resp"}, 32'(bus.stall), 32'd0);
                end
            end
        end
    end

    // Issue one request, hold it through the RESP edge, check stall/latency.
    // Inputs are scrambled mid-access to show they are ignored after accept.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                          input string nm);
        int   n_neg;
        int   n_stall;
        bit   got;
        exp_t e;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        e.data = ed;
        e.err  = ee;
        e.name = nm;
        sb_q.push_back(e);
        n_neg   = 0;
        n_stall = 0;
        got     = 0;
        while (!got && n_neg < 20) begin
            @(negedge clk);
            n_neg++;
            if (bus.stall === 1'b1) n_stall++;
            if (bus.resp_valid === 1'b1) got = 1;
            if (n_neg == 2) begin
                bus.req_addr  = addr ^ 32'h0000_0ffc;
                bus.req_wdata = ~wd;
                bus.req_write = ~wr;
            end
        end
        if (!got) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s_timeout: got no resp_valid in 20 cycles, required one", nm);
        end else begin
            check({nm, "_latency"}, 32'(n_neg), 32'(LAT + 2));
            check({nm, "_stall_cycles"}, 32'(n_stall), 32'(LAT + 1));
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_readdata", bus.ReadData, 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Word store/load
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw_10");
        do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10");
        // Byte store into a known word
        do_req(1'b1, 3'b010, 32'h20, 32'h44332211, 32'h0,        1'b0, "sw_20");
        do_req(1'b1, 3'b000, 32'h21, 32'h12345680, 32'h0,        1'b0, "sb_21");
        do_req(1'b0, 3'b000, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, "lb_21");
        do_req(1'b0, 3'b100, 32'h21, 32'h0,        32'h00000080, 1'b0, "lbu_21");
        do_req(1'b0, 3'b010, 32'h20, 32'h0,        32'h44338011, 1'b0, "lw_20");
        // Halfwords in both halves of a word
        do_req(1'b1, 3'b001, 32'h30, 32'hABCD8001, 32'h0,        1'b0, "sh_30");
        do_req(1'b0, 3'b001, 32'h30, 32'h0,        32'hFFFF8001, 1'b0, "lh_30");
        do_req(1'b0, 3'b101, 32'h30, 32'h0,        32'h00008001, 1'b0, "lhu_30");
        do_req(1'b1, 3'b001, 32'h32, 32'h55557FFE, 32'h0,        1'b0, "sh_32");
        do_req(1'b0, 3'b001, 32'h32, 32'h0,        32'h00007FFE, 1'b0, "lh_32");
        do_req(1'b0, 3'b010, 32'h30, 32'h0,        32'h7FFE8001, 1'b0, "lw_30");
        // Errors
        do_req(1'b0, 3'b001, 32'h03, 32'h0,        32'h0,        1'b1, "lh_03_mis");
        do_req(1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 32'h0,        1'b0, "sw_40");
        do_req(1'b1, 3'b010, 32'h42, 32'hFFFFFFFF, 32'h0,        1'b1, "sw_42_mis");
        do_req(1'b1, 3'b100, 32'h40, 32'h00000000, 32'h0,        1'b1, "st_f3_100");
        do_req(1'b0, 3'b011, 32'h40, 32'h0,        32'h0,        1'b1, "ld_f3_011");
        do_req(1'b0, 3'b010, 32'h40, 32'h0,        32'hA5A5A5A5, 1'b0, "lw_40");
        do_req(1'b0, 3'b000, 32'h43, 32'h0,        32'hFFFFFFA5, 1'b0, "lb_43");
        // Reset aborting a store in BUSY
        do_req(1'b1, 3'b010, 32'h50, 32'h11112222, 32'h0,        1'b0, "sw_50");
        do_req(1'b0, 3'b010, 32'h50, 32'h0,        32'h11112222, 1'b0, "lw_50_pre");
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h50;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        check("abort_busy_stall", 32'(bus.stall), 32'd1);
        check("abort_busy_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_readdata", bus.ReadData, 32'h0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset pulsed during BUSY of sw_50_abort");
        do_req(1'b0, 3'b010, 32'h50, 32'h0,        32'h11112222, 1'b0, "lw_50_post");
        // Address wrap
        do_req(1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, 32'h0,      1'b0, "sw_1004");
        do_req(1'b0, 3'b010, 32'h0004, 32'h0,      32'hCAFEF00D, 1'b0, "lw_0004");
        do_req(1'b0, 3'b000, 32'hF007, 32'h0,      32'hFFFFFFCA, 1'b0, "lb_f007");

        repeat (10) @(posedge clk);
        #1;
        check("no_outstanding", 32'(sb_q.size()), 32'd0);
        check("idle_ready", 32'(bus.req_ready), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder serving the MEM-stage load/store requests of the pipelined core. It supplies `ReadData` to the MEM/WB register.
- Adds configurable wait states and a stall output, so the pipeline freezes until the access completes.
- Supports RV32I byte, half and word accesses (little-endian) with load sign/zero extension and misalignment detection.

Parameters:
- DATA_WIDTH, 32, data word width (fixed at 32 for RV32I).
- ADDR_WIDTH, 12, byte-address bits decoded. Memory holds 2^ADDR_WIDTH bytes; upper address bits are ignored, so addresses wrap.
- LATENCY, 2, wait states, integer ≥1. Equals the number of clock edges from acceptance to completion.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM stage has a load/store request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 width/sign code
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  store data; the low bytes are used for SB/SH
- req_ready  out  1  responder can accept a request
- resp_valid  out  1  one-cycle completion pulse
- ReadData  out  DATA_WIDTH  extended load result, held until the next completion
- resp_err  out  1  misaligned or illegal access; qualified by resp_valid
- stall  out  1  freeze PC/IF/ID/EX/MEM

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE; ReadData=0; resp_valid=0; resp_err=0; wait counter=0.
  - Memory array is not cleared.
  - Reset during BUSY aborts the access; a pending store is NOT written.
- States: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. When req_valid=1 at an edge, capture write/funct3/addr/wdata, load counter with LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Counter decrements each edge. At the edge where counter==0, perform the access, register ReadData/resp_err, go to RESP.
  - RESP: lasts exactly one cycle with resp_valid=1 and req_ready=0. Then return to IDLE unconditionally.
  - RESP blocks re-acceptance of the still-held request, because the pipeline advances on the RESP-cycle edge.
- stall (combinational) = (state==BUSY) | (state==IDLE & req_valid). It is 0 in RESP.
- Latency and throughput:
  - resp_valid rises LATENCY edges after the accepting edge.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Loads, with a = addr[ADDR_WIDTH-1:0]:
  - 000 LB: sign-extend mem[a].
  - 001 LH: sign-extend {mem[a+1],mem[a]}.
  - 010 LW: {mem[a+3..a]}.
  - 100 LBU and 101 LHU: zero-extend.
- Stores:
  - 000 SB writes 1 byte.
  - 001 SH writes 2 bytes.
  - 010 SW writes 4 bytes.
  - Stores update ReadData to 0.
- Errors:
  - Halfword with a[0]=1, word with a[1:0]≠0, or any other funct3 sets resp_err=1 and ReadData=0.
  - An erroring store leaves memory unchanged.
  - Errors still follow the normal timing: BUSY for LATENCY edges, then RESP.
- Wrap-around: a is truncated before indexing, so byte a+k never exceeds the array (aligned accesses cannot straddle).
- req_* inputs are ignored outside IDLE; changing them mid-access has no effect.
- Load after store to the same address returns the stored data, because the store commits before RESP.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 → each access shows stall high for 3 cycles and a 1-cycle resp_valid, with resp_valid 2 edges after acceptance. The load returns ReadData=0xDEADBEEF, resp_err=0.
- SB 0x80 @0x21, then LB @0x21 → 0xFFFFFF80. LBU @0x21 → 0x00000080. LW @0x20 → byte lane 1 = 0x80, other lanes unchanged.
- SH 0x8001 @0x30, then LH → 0xFFFF8001; LHU → 0x00008001.
- LH @0x03 → resp_err=1, ReadData=0. SW @0x42 → resp_err=1, and LW @0x40 is unchanged afterwards.
- SW 0x12345678 @0x50, with rst_n pulsed low during BUSY → outputs reset immediately; a subsequent LW @0x50 returns the old value.
- ADDR_WIDTH=12: SW 0xCAFEF00D @0x1004, then LW @0x0004 → 0xCAFEF00D (wrap). req_valid held through RESP → no second acceptance; req_ready=0 in RESP.
